// File: rtl/clock_phase_ctrl.sv
// ============================================================================
// Module      : clock_phase_ctrl
// Description : Derives the four skeleton-CPU clocks from the master clock
//               using a 4-phase sequencer, stretches reset for the core,
//               counts processor cycles and freezes the clocks on request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_phase_ctrl #(
    parameter int unsigned RESET_HOLD = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             halt_req,
    output logic             imem_clock,
    output logic             dmem_clock,
    output logic             processor_clock,
    output logic             regfile_clock,
    output logic             core_reset,
    output logic             halted,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] proc_cycle
);

    localparam logic [7:0] HOLD_LIMIT = 8'(RESET_HOLD);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_hold;
    logic [7:0]       w_hold_nxt;
    logic [1:0]       w_phase_nxt;
    logic             w_imem_nxt;
    logic             w_dmem_nxt;
    logic             w_proc_nxt;
    logic             w_rf_nxt;
    logic             w_core_reset_nxt;
    logic             w_halted_nxt;
    logic [CNT_W-1:0] w_cycle_nxt;
    logic             w_advance;
    logic             w_entry;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold;
        w_phase_nxt      = phase;
        w_imem_nxt       = imem_clock;
        w_dmem_nxt       = dmem_clock;
        w_proc_nxt       = processor_clock;
        w_rf_nxt         = regfile_clock;
        w_core_reset_nxt = core_reset;
        w_halted_nxt     = halted;
        w_cycle_nxt      = proc_cycle;
        w_advance        = 1'b0;

        case (r_state)
            ST_RUN: begin
                // Halt only at the end of a full processor cycle.
                if (halt_req && (phase == 2'd3)) begin
                    w_state_nxt  = ST_HALT;
                    w_imem_nxt   = 1'b0;
                    w_dmem_nxt   = 1'b0;
                    w_proc_nxt   = 1'b0;
                    w_rf_nxt     = 1'b0;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_phase_nxt = phase + 2'd1;
                    w_advance   = 1'b1;
                end
            end
            ST_HALT: begin
                // Leaving halt starts a fresh processor cycle at phase 0.
                if (!halt_req) begin
                    w_state_nxt  = ST_RUN;
                    w_phase_nxt  = 2'd0;
                    w_halted_nxt = 1'b0;
                    w_advance    = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        w_entry = w_advance && (w_phase_nxt == 2'd0);

        if (w_advance) begin
            w_proc_nxt = (w_phase_nxt < 2'd2);
            w_rf_nxt   = (w_phase_nxt >= 2'd2);
            w_imem_nxt = ~w_phase_nxt[0];
            w_dmem_nxt = w_phase_nxt[0];
        end

        // Phase-0 entry: count the cycle and step the reset stretch, so
        // core_reset only ever drops together with a processor_clock rise.
        if (w_entry) begin
            w_cycle_nxt = proc_cycle + CNT_W'(1);
            if (r_hold == HOLD_LIMIT) begin
                w_core_reset_nxt = 1'b0;
            end else begin
                w_hold_nxt = r_hold + 8'd1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_RUN;
            r_hold          <= 8'd0;
            phase           <= 2'd3;
            imem_clock      <= 1'b0;
            dmem_clock      <= 1'b0;
            processor_clock <= 1'b0;
            regfile_clock   <= 1'b0;
            core_reset      <= 1'b1;
            halted          <= 1'b0;
            proc_cycle      <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_hold          <= w_hold_nxt;
            phase           <= w_phase_nxt;
            imem_clock      <= w_imem_nxt;
            dmem_clock      <= w_dmem_nxt;
            processor_clock <= w_proc_nxt;
            regfile_clock   <= w_rf_nxt;
            core_reset      <= w_core_reset_nxt;
            halted          <= w_halted_nxt;
            proc_cycle      <= w_cycle_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clock_phase_ctrl.sv
// ============================================================================
// Module      : tb_clock_phase_ctrl
// Description : Self-checking bench for clock_phase_ctrl. Two instances share
//               stimulus: A (RESET_HOLD=2, CNT_W=32), B (RESET_HOLD=0,
//               CNT_W=4). A cycle-level reference model predicts both.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_phase_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic halt_req = 1'b0;

    logic a_imem, a_dmem, a_proc, a_rf, a_creset, a_halted;
    logic [1:0]  a_phase;
    logic [31:0] a_cycle;
    logic b_imem, b_dmem, b_proc, b_rf, b_creset, b_halted;
    logic [1:0]  b_phase;
    logic [3:0]  b_cycle;

    int checks = 0;
    int errors = 0;

    // Reference model: processor-cycle view of the controller.
    int     m_phase   = 3;
    bit     m_off     = 1'b1;   // derived clocks forced low (reset / halt)
    bit     m_halted  = 1'b0;
    longint m_cycles  = 0;      // processor cycles started since reset
    longint m_entries = 0;      // phase-0 entries since reset
    // {P,I,D,R} for phases 0..3
    logic [3:0] pat [4] = '{4'b1100, 4'b1010, 4'b0101, 4'b0011};

    int  rise_i = 0, rise_p = 0;
    logic prev_i = 1'b0, prev_p = 1'b0;

    always #5 clock = ~clock;

    clock_phase_ctrl #(.RESET_HOLD(2), .CNT_W(32)) u_a (
        .clock(clock), .reset(reset), .halt_req(halt_req),
        .imem_clock(a_imem), .dmem_clock(a_dmem),
        .processor_clock(a_proc), .regfile_clock(a_rf),
        .core_reset(a_creset), .halted(a_halted),
        .phase(a_phase), .proc_cycle(a_cycle)
    );

    clock_phase_ctrl #(.RESET_HOLD(0), .CNT_W(4)) u_b (
        .clock(clock), .reset(reset), .halt_req(halt_req),
        .imem_clock(b_imem), .dmem_clock(b_dmem),
        .processor_clock(b_proc), .regfile_clock(b_rf),
        .core_reset(b_creset), .halted(b_halted),
        .phase(b_phase), .proc_cycle(b_cycle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic hreq);
        if (rst) begin
            m_phase = 3; m_off = 1'b1; m_halted = 1'b0;
            m_cycles = 0; m_entries = 0;
        end else if (!m_halted && hreq && m_phase == 3) begin
            m_halted = 1'b1; m_off = 1'b1;
        end else if (m_halted && hreq) begin
            // stay frozen
        end else begin
            m_phase  = (m_phase + 1) % 4;
            m_off    = 1'b0;
            m_halted = 1'b0;
            if (m_phase == 0) begin
                m_cycles++;
                m_entries++;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] e_clk;
        e_clk = m_off ? 4'b0000 : pat[m_phase];
        chk("A.clocks",     {60'd0, a_proc, a_imem, a_dmem, a_rf}, {60'd0, e_clk});
        chk("A.phase",      64'(a_phase), 64'(m_phase));
        chk("A.halted",     64'(a_halted), 64'(m_halted));
        chk("A.core_reset", 64'(a_creset), 64'(m_entries <= 2));
        chk("A.proc_cycle", 64'(a_cycle), 64'(m_cycles % (64'd1 << 32)));
        chk("B.clocks",     {60'd0, b_proc, b_imem, b_dmem, b_rf}, {60'd0, e_clk});
        chk("B.phase",      64'(b_phase), 64'(m_phase));
        chk("B.halted",     64'(b_halted), 64'(m_halted));
        chk("B.core_reset", 64'(b_creset), 64'(m_entries <= 0));
        chk("B.proc_cycle", 64'(b_cycle), 64'(m_cycles % 16));
    endtask

    // One master clock edge: advance the model with the sampled inputs,
    // then inspect the DUT 1 ns after the edge.
    task automatic tick();
        @(posedge clock);
        model_step(reset, halt_req);
        #1;
        if (a_imem && !prev_i) rise_i++;
        if (a_proc && !prev_p) rise_p++;
        prev_i = a_imem;
        prev_p = a_proc;
        check_model();
    endtask

    initial begin
        // Reset for 5 clocks
        reset = 1'b1; halt_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("reset.phase", 64'(a_phase), 64'd3);
        chk("reset.core_reset", 64'(a_creset), 64'd1);
        chk("reset.proc_cycle", 64'(a_cycle), 64'd0);

        // 100 free-running clocks
        reset = 1'b0;
        rise_i = 0; rise_p = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i <= 4)
                chk("pattern.PIDR", {60'd0, a_proc, a_imem, a_dmem, a_rf},
                    {60'd0, pat[i-1]});
            if (i == 1) chk("B.core_reset_edge1", 64'(b_creset), 64'd0);
            if (i == 8) chk("A.core_reset_edge8", 64'(a_creset), 64'd1);
            if (i == 9) chk("A.core_reset_edge9", 64'(a_creset), 64'd0);
            if (i == 65) chk("B.wrap17", 64'(b_cycle), 64'd1);
        end
        chk("run.proc_cycle", 64'(a_cycle), 64'd25);
        chk("run.phase", 64'(a_phase), 64'd3);
        chk("run.imem_rises", 64'(rise_i), 64'd50);
        chk("run.proc_rises", 64'(rise_p), 64'd25);

        // Halt raised in phase 1: cycle completes, then clocks freeze
        tick(); tick();
        chk("halt.start_phase", 64'(a_phase), 64'd1);
        halt_req = 1'b1;
        tick(); tick();
        chk("halt.phase3_running", {60'd0, a_proc, a_imem, a_dmem, a_rf}, 64'b0011);
        tick();
        chk("halt.halted", 64'(a_halted), 64'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("halt.frozen_count", 64'(a_cycle), 64'd26);
        halt_req = 1'b0;
        tick();
        chk("resume.phase", 64'(a_phase), 64'd0);
        chk("resume.proc_clock", 64'(a_proc), 64'd1);
        chk("resume.count", 64'(a_cycle), 64'd27);

        // Reset pulse at phase 2 restarts everything including the stretch
        for (int i = 0; i < 8 && m_phase != 2; i++) tick();
        chk("rst2.reached_phase2", 64'(m_phase), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2.phase", 64'(a_phase), 64'd3);
        chk("rst2.clocks", {60'd0, a_proc, a_imem, a_dmem, a_rf}, 64'd0);
        chk("rst2.proc_cycle", 64'(a_cycle), 64'd0);
        chk("rst2.core_reset", 64'(a_creset), 64'd1);
        for (int i = 0; i < 12; i++) tick();

        // Randomized halt/reset traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0; halt_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
